// File: rtl/pps_pkg.sv
// Shared definitions for the memory-access pipeline stage: access sizes,
// FSM states and the misalignment rule.
package pps_pkg;

  localparam int RWE_SIZE_DEF = 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Size 2'b11 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/pps_load_align.sv
// Selects the addressed byte/half lane of a load word and zero- or
// sign-extends it to 32 bits; word loads pass straight through.
module pps_load_align
  import pps_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: result = {{24{sgn & byte_v[7]}}, byte_v};
      SZ_HALF: result = {{16{sgn & half_v[15]}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/pps_memory_access.sv
// MIPS memory-access stage: issues SRAM load/store requests over a req/ack
// handshake, stalls upstream while a request is outstanding, feeds MEM/WB.
module pps_memory_access
  import pps_pkg::*;
#(
  parameter int RWE_SIZE = RWE_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                MEM_valid,
  input  logic [31:0]         MEM_ALU_result,
  input  logic [31:0]         MEM_store_data,
  input  logic [4:0]          MEM_inst_rd,
  input  logic [RWE_SIZE-1:0] MEM_RegWrite,
  input  logic                MEM_MemRead,
  input  logic                MEM_MemWrite,
  input  logic [1:0]          MEM_mem_size,
  input  logic                MEM_mem_signed,
  output logic                MEM_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [29:0]         mem_addr,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack,
  output logic                exc_misalign,
  output logic [4:0]          WB_inst_rd,
  output logic [RWE_SIZE-1:0] WB_RegWrite,
  output logic [31:0]         WB_RF_Wdata
);

  state_t state, state_nxt;

  logic                issue, done, misal, alu_pass;
  logic [3:0]          be_nxt;
  logic [31:0]         wdata_nxt;
  logic [RWE_SIZE-1:0] rwe_in;
  logic [4:0]          rd_q;
  logic [RWE_SIZE-1:0] rwe_q;
  logic [1:0]          size_q;
  logic                sgn_q;
  logic [1:0]          lo_q;
  logic [31:0]         load_data;

  assign rwe_in = (MEM_inst_rd == 5'd0) ? '0 : MEM_RegWrite;

  always_comb begin
    state_nxt = state;
    MEM_stall = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    misal     = 1'b0;
    alu_pass  = 1'b0;
    case (state)
      IDLE: begin
        if (MEM_valid && (MEM_MemRead || MEM_MemWrite)) begin
          if (is_misaligned(MEM_mem_size, MEM_ALU_result[1:0])) begin
            misal = 1'b1;
          end else begin
            issue     = 1'b1;
            MEM_stall = 1'b1;
            state_nxt = ACCESS;
          end
        end else if (MEM_valid) begin
          alu_pass = 1'b1;
        end
      end
      ACCESS: begin
        MEM_stall = !mem_ack;
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Loads always fetch the full word; lane selection happens on return.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = MEM_store_data;
    if (MEM_MemWrite) begin
      case (MEM_mem_size)
        SZ_BYTE: begin
          be_nxt    = 4'b0001 << MEM_ALU_result[1:0];
          wdata_nxt = {4{MEM_store_data[7:0]}};
        end
        SZ_HALF: begin
          be_nxt    = MEM_ALU_result[1] ? 4'b1100 : 4'b0011;
          wdata_nxt = {2{MEM_store_data[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = MEM_store_data;
        end
      endcase
    end
  end

  pps_load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (lo_q),
    .size    (size_q),
    .sgn     (sgn_q),
    .result  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      exc_misalign <= 1'b0;
      rd_q         <= '0;
      rwe_q        <= '0;
      size_q       <= '0;
      sgn_q        <= 1'b0;
      lo_q         <= '0;
      WB_inst_rd   <= '0;
      WB_RegWrite  <= '0;
      WB_RF_Wdata  <= '0;
    end else begin
      exc_misalign <= misal;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= MEM_MemWrite;
        mem_addr  <= MEM_ALU_result[31:2];
        mem_be    <= be_nxt;
        mem_wdata <= wdata_nxt;
        rd_q      <= MEM_inst_rd;
        rwe_q     <= rwe_in;
        size_q    <= MEM_mem_size;
        sgn_q     <= MEM_mem_signed;
        lo_q      <= MEM_ALU_result[1:0];
      end else if (done) begin
        mem_req <= 1'b0;
      end

      if (alu_pass) begin
        WB_inst_rd  <= MEM_inst_rd;
        WB_RegWrite <= rwe_in;
        WB_RF_Wdata <= MEM_ALU_result;
      end else if (done && !mem_we) begin
        WB_inst_rd  <= rd_q;
        WB_RegWrite <= rwe_q;
        WB_RF_Wdata <= load_data;
      end else begin
        WB_RegWrite <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pps_memory_access.sv
// Directed and randomized bench for pps_memory_access, checked against an
// arithmetic model of lane selection, extension and byte enables.
module tb_pps_memory_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_valid;
  logic [31:0] MEM_ALU_result;
  logic [31:0] MEM_store_data;
  logic [4:0]  MEM_inst_rd;
  logic [0:0]  MEM_RegWrite;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [1:0]  MEM_mem_size;
  logic        MEM_mem_signed;
  logic        MEM_stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        exc_misalign;
  logic [4:0]  WB_inst_rd;
  logic [0:0]  WB_RegWrite;
  logic [31:0] WB_RF_Wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pps_memory_access #(.RWE_SIZE(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .MEM_valid      (MEM_valid),
    .MEM_ALU_result (MEM_ALU_result),
    .MEM_store_data (MEM_store_data),
    .MEM_inst_rd    (MEM_inst_rd),
    .MEM_RegWrite   (MEM_RegWrite),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_MemWrite   (MEM_MemWrite),
    .MEM_mem_size   (MEM_mem_size),
    .MEM_mem_signed (MEM_mem_signed),
    .MEM_stall      (MEM_stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .exc_misalign   (exc_misalign),
    .WB_inst_rd     (WB_inst_rd),
    .WB_RegWrite    (WB_RegWrite),
    .WB_RF_Wdata    (WB_RF_Wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_misal(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b00) return 1'b0;
    if (size == 2'b01) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [3:0] m_be(input bit load, input logic [1:0] size, input logic [31:0] addr);
    int lo;
    lo = int'(addr % 4);
    if (load) return 4'hF;
    if (size == 2'b00) return 4'(1 << lo);
    if (size == 2'b01) return (lo >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] rt);
    if (size == 2'b00) return (rt % 256) * 32'h0101_0101;
    if (size == 2'b01) return (rt % 65536) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                         input logic [1:0] size, input logic sgn);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = (rdata >> (8 * (addr % 4))) % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (rdata >> (16 * ((addr % 4) / 2))) % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input logic rwe);
    MEM_valid = 1'b1; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
    MEM_ALU_result = res; MEM_inst_rd = rd; MEM_RegWrite = rwe;
    #1;
    chk("alu_stall", 32'(MEM_stall), 32'd0);
    step();
    chk("alu_wdata", WB_RF_Wdata, res);
    chk("alu_rd", 32'(WB_inst_rd), 32'(rd));
    chk("alu_rwe", 32'(WB_RegWrite), (rd != 0) ? 32'(rwe) : 32'd0);
    chk("alu_req", 32'(mem_req), 32'd0);
  endtask

  task automatic bubble(input logic spur_ack);
    MEM_valid = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
    mem_ack = spur_ack;
    step();
    mem_ack = 1'b0;
    chk("bub_rwe", 32'(WB_RegWrite), 32'd0);
    chk("bub_req", 32'(mem_req), 32'd0);
  endtask

  task automatic mem_op(input string nm, input bit load, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [4:0] rd, input logic rwe, input logic [1:0] size, input logic sgn,
                        input int n, input logic [31:0] rdata, output int stalls);
    bit mis;
    mis = m_misal(size, addr);
    MEM_valid = 1'b1; MEM_MemRead = load; MEM_MemWrite = !load;
    MEM_ALU_result = addr; MEM_store_data = rt; MEM_inst_rd = rd; MEM_RegWrite = rwe;
    MEM_mem_size = size; MEM_mem_signed = sgn;
    #1;
    chk({nm, "_req_gap"}, 32'(mem_req), 32'd0);
    chk({nm, "_stall_issue"}, 32'(MEM_stall), mis ? 32'd0 : 32'd1);
    stalls = int'(MEM_stall);
    step();
    if (mis) begin
      chk({nm, "_exc"}, 32'(exc_misalign), 32'd1);
      chk({nm, "_mis_req"}, 32'(mem_req), 32'd0);
      chk({nm, "_mis_rwe"}, 32'(WB_RegWrite), 32'd0);
      MEM_valid = 1'b0;
      step();
      chk({nm, "_exc_end"}, 32'(exc_misalign), 32'd0);
      chk({nm, "_mis_req2"}, 32'(mem_req), 32'd0);
      return;
    end
    chk({nm, "_req"}, 32'(mem_req), 32'd1);
    chk({nm, "_addr"}, {2'b00, mem_addr}, addr / 4);
    chk({nm, "_we"}, 32'(mem_we), 32'(!load));
    chk({nm, "_be"}, 32'(mem_be), 32'(m_be(load, size, addr)));
    if (!load) chk({nm, "_wdata"}, mem_wdata, m_wdata(size, rt));
    chk({nm, "_rwe_issue"}, 32'(WB_RegWrite), 32'd0);
    for (int k = 1; k <= n; k++) begin
      if (k == n) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end else begin
        mem_rdata = $urandom;
      end
      #1;
      if (MEM_stall) stalls++;
      chk({nm, "_stall_acc"}, 32'(MEM_stall), (k != n) ? 32'd1 : 32'd0);
      chk({nm, "_req_hold"}, 32'(mem_req), 32'd1);
      step();
      mem_ack = 1'b0;
    end
    mem_rdata = $urandom;
    chk({nm, "_req_drop"}, 32'(mem_req), 32'd0);
    if (load) begin
      chk({nm, "_wb_rwe"}, 32'(WB_RegWrite), (rd != 0) ? 32'(rwe) : 32'd0);
      chk({nm, "_wb_rd"}, 32'(WB_inst_rd), 32'(rd));
      chk({nm, "_wb_data"}, WB_RF_Wdata, m_load(rdata, addr, size, sgn));
    end else begin
      chk({nm, "_wb_rwe"}, 32'(WB_RegWrite), 32'd0);
    end
    MEM_valid = 1'b0;
  endtask

  initial begin
    int st;
    rst_n = 1'b0;
    MEM_valid = 1'b0; MEM_ALU_result = '0; MEM_store_data = '0; MEM_inst_rd = '0;
    MEM_RegWrite = '0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_mem_size = '0;
    MEM_mem_signed = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", {2'b00, mem_addr}, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_exc", 32'(exc_misalign), 32'd0);
    chk("rst_wb_rd", 32'(WB_inst_rd), 32'd0);
    chk("rst_wb_rwe", 32'(WB_RegWrite), 32'd0);
    chk("rst_wb_data", WB_RF_Wdata, 32'd0);
    chk("rst_stall", 32'(MEM_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    alu_op(32'h1234_5678, 5'd5, 1'b1);
    bubble(1'b0);

    mem_op("lb", 1'b1, 32'h0000_0103, 32'h0, 5'd9, 1'b1, 2'b00, 1'b1, 3, 32'h80FF_0000, st);
    chk("lb_stall_cycles", 32'(st), 32'd3);

    mem_op("lhu", 1'b1, 32'h0000_0202, 32'h0, 5'd10, 1'b1, 2'b01, 1'b0, 1, 32'hBEEF_0000, st);
    chk("lhu_stall_cycles", 32'(st), 32'd1);

    mem_op("sb", 1'b0, 32'h0000_0301, 32'h0000_00AB, 5'd11, 1'b0, 2'b00, 1'b0, 2, 32'h0, st);
    mem_op("lw_mis", 1'b1, 32'h0000_0402, 32'h0, 5'd12, 1'b1, 2'b10, 1'b0, 1, 32'h0, st);
    mem_op("lw_rd0", 1'b1, 32'h0000_0404, 32'h0, 5'd0, 1'b1, 2'b10, 1'b0, 2, 32'hCAFE_F00D, st);
    alu_op(32'hDEAD_BEEF, 5'd0, 1'b1);

    // abandon a transaction with reset
    MEM_valid = 1'b1; MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0;
    MEM_ALU_result = 32'h0000_0500; MEM_inst_rd = 5'd7; MEM_RegWrite = 1'b1; MEM_mem_size = 2'b10;
    step();
    chk("rst_acc_req_on", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_acc_req_drop", 32'(mem_req), 32'd0);
    MEM_valid = 1'b0; MEM_MemRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_acc_addr", {2'b00, mem_addr}, 32'd0);
    chk("rst_acc_be", 32'(mem_be), 32'd0);
    chk("rst_acc_wb_data", WB_RF_Wdata, 32'd0);
    chk("rst_acc_stall", 32'(MEM_stall), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_rwe", 32'(WB_RegWrite), 32'd0);
    chk("late_ack_data", WB_RF_Wdata, 32'd0);
    chk("late_ack_stall", 32'(MEM_stall), 32'd0);

    for (int i = 0; i < 80; i++) begin
      int kind;
      logic [4:0] rd;
      kind = int'($urandom_range(0, 4));
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      case (kind)
        0: alu_op($urandom, rd, 1'($urandom));
        1: bubble(1'($urandom));
        default:
          mem_op("rnd", kind != 3, $urandom, $urandom, rd, 1'($urandom), 2'($urandom),
                 1'($urandom), int'($urandom_range(1, 4)), $urandom, st);
      endcase
    end
    bubble(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pps_memory_access.md
# pps_memory_access

Memory-access pipeline stage of the MIPS core, placed between the execute stage and the writeback stage. It issues load and store transactions to the external SRAM controller through a request/acknowledge handshake. While a transaction is outstanding it stalls the upstream pipeline. It aligns and extends load data, then registers the destination register, write enable and write data into the MEM/WB boundary, which the writeback stage consumes unchanged.

## Interface
- RWE_SIZE, 1, width of the register-write-enable field, same as the writeback stage.
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MEM_valid  in  1  an instruction is present from execute.
- MEM_ALU_result  in  32  effective address, or the result for non-memory instructions.
- MEM_store_data  in  32  rt value for stores.
- MEM_inst_rd  in  5  destination register.
- MEM_RegWrite  in  RWE_SIZE  register-write enable.
- MEM_MemRead, MEM_MemWrite  in  1  load / store (mutually exclusive).
- MEM_mem_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- MEM_mem_signed  in  1  sign-extend load (lb/lh); 0 = lbu/lhu.
- MEM_stall  out  1  hold upstream registers this cycle.
- mem_req  out  1  SRAM request, registered.
- mem_we  out  1  1 = write.
- mem_addr  out  30  word address (byte address [31:2]).
- mem_be  out  4  byte enables; bit i = byte lane i (little-endian).
- mem_wdata  out  32  store data, lane-replicated.
- mem_rdata  in  32  read data, valid in the cycle mem_ack=1.
- mem_ack  in  1  one-cycle completion pulse.
- exc_misalign  out  1  one-cycle pulse on a misaligned access.
- WB_inst_rd  out  5  to writeback.
- WB_RegWrite  out  RWE_SIZE  to writeback.
- WB_RF_Wdata  out  32  to writeback.

## Operation
- States: IDLE, ACCESS.
- IDLE, non-memory valid instruction: WB_* load MEM_inst_rd, MEM_RegWrite and MEM_ALU_result. MEM_stall=0.
- IDLE, not valid: WB_RegWrite loads 0 (bubble).
- IDLE, valid aligned load/store:
  - MEM_stall=1 combinationally.
  - At the clock edge: latch mem_addr, mem_we, mem_be and mem_wdata, plus the rd, size, signed flag and addr[1:0]; set mem_req=1; go to ACCESS.
  - WB_RegWrite loads 0.
- Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0):
  - No request is issued and MEM_stall=0.
  - exc_misalign=1 for one cycle after the edge; WB_RegWrite loads 0.
- ACCESS:
  - mem_req and all request fields stay stable.
  - MEM_stall = !mem_ack.
  - On mem_ack: mem_req→0 and state→IDLE at the edge.
    - Load: WB_RF_Wdata = aligned/extended mem_rdata; WB_RegWrite = latched enable; WB_inst_rd = latched rd.
    - Store: WB_RegWrite = 0.
- Store byte enables:
  - byte: 1<<addr[1:0], wdata = {4{rt[7:0]}}.
  - half: addr[1] ? 1100 : 0011, wdata = {2{rt[15:0]}}.
  - word: 1111, wdata = rt.
- Load extraction:
  - byte lane addr[1:0]; half lane addr[1].
  - Zero- or sign-extend to 32 bits per the signed flag.
  - Word loads pass through unchanged.
- WB_RegWrite is forced to 0 whenever rd = 0.
- mem_ack while in IDLE is ignored.

## Timing
- Reset values: state IDLE; mem_req, mem_we, mem_addr, mem_be, mem_wdata, exc_misalign, WB_inst_rd, WB_RegWrite, WB_RF_Wdata all 0.
- Reset asserted during ACCESS: mem_req drops immediately (asynchronously) and the transaction is abandoned.
- Non-memory instruction latency: 1 cycle to the WB_* outputs.
- Memory instruction latency: 1 cycle to mem_req, then N cycles until mem_ack. WB_* update at the ack edge.
- Minimum memory instruction latency: 2 cycles (ack in the first ACCESS cycle). In that case the stall lasts exactly 1 cycle.
- Upstream holds its instruction while MEM_stall=1. The next instruction is accepted in the cycle after the ack edge.
- Back-to-back memory instructions: at most one transaction is outstanding, and mem_req is low for at least one cycle between them.

## Structure
- Shared package pps_pkg:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD;
  - the state enum {IDLE, ACCESS};
  - RWE_SIZE default.
- Sub-module pps_load_align (combinational): rdata, addr[1:0], size and signed in; 32-bit result out.
- Byte-enable and store-lane generation stays inline.

## Test plan
- Non-memory instruction: ALU result 0x1234_5678, rd=5 → next cycle WB_RF_Wdata=0x1234_5678, WB_RegWrite=1, no mem_req, MEM_stall=0.
- lb from addr 0x103 with signed=1, ack after 3 cycles, rdata 0x80FF_0000 → mem_be=1111, mem_addr=0x40, stall held 3 cycles, WB_RF_Wdata=0xFFFF_FF80.
- lhu from addr 0x202, ack in the first ACCESS cycle, rdata 0xBEEF_0000 → WB_RF_Wdata=0x0000_BEEF, stall exactly 1 cycle.
- sb of rt=0xAB to addr 0x301 → mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB, WB_RegWrite=0 after ack.
- lw from 0x402 → exc_misalign pulses 1 cycle, mem_req stays 0, WB_RegWrite=0; a load with rd=0 also gives WB_RegWrite=0.
- rst_n low for 1 cycle mid-ACCESS → mem_req drops immediately, state IDLE, all outputs 0; a later mem_ack has no effect.
